mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM stage.
- Consumes the EX/MEM outputs: write-back control, memory control, memory address, store data, ALU result and destination register.
- Drives a variable-latency data memory over a req/ack handshake and stalls the upstream pipeline until the access completes.
- Registers the write-back result for the register file and for the forwarding unit.

Parameters:
- TIMEOUT, 64, maximum cycles to wait for mem_ack_i before aborting; 0 disables the timeout.
- DATA_W, 32, data and address width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-low
- WB_i  in  1  RegWrite for the instruction in this stage
- Mem_i  in  2  memory op: bit1 = MemWrite, bit0 = MemRead; 00 = none; 11 = illegal
- Memaddr_i  in  32  byte address, word access
- Memdata_i  in  32  store data
- ALUres_i  in  32  ALU result, written back for non-load instructions
- rd_addr_i  in  5  destination register
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = store, 0 = load
- mem_addr_o  out  32  equals Memaddr_i
- mem_wdata_o  out  32  equals Memdata_i
- mem_rdata_i  in  32  load data, valid with mem_ack_i
- mem_ack_i  in  1  access complete this cycle
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- RegWrite_o  out  1  MEM/WB register: write enable
- rd_addr_o  out  5  MEM/WB register: destination
- wb_data_o  out  32  MEM/WB register: write-back data
- err_o  out  1  one-cycle pulse on timeout or illegal Mem_i

Behaviour:
- Reset (rst_i low, asynchronous):
  - state = IDLE, timeout counter = 0.
  - RegWrite_o = 0, rd_addr_o = 0, wb_data_o = 0, err_o = 0.
  - mem_req_o drops immediately.
  - An in-flight access is abandoned; a late ack after reset is ignored.
- Let op = (Mem_i == 01 || Mem_i == 10).
- Combinational outputs:
  - mem_req_o = op in IDLE or WAIT.
  - mem_we_o = Mem_i[1].
  - stall_o = op & ~mem_ack_i & ~timeout_hit.
- State machine (2 states; the counter counts cycles spent in WAIT):
  - IDLE, op & ack: zero-wait access, completes this cycle, stay IDLE, no stall.
  - IDLE, op & ~ack: go to WAIT, counter = 1.
  - WAIT, ack: complete, go to IDLE, counter = 0.
  - WAIT, ~ack: counter += 1. When counter == TIMEOUT (TIMEOUT != 0), timeout_hit = 1: abort, err_o pulses the next cycle, go to IDLE.
- Upstream holds all *_i stable while stall_o = 1. The instruction advances at the first edge where stall_o = 0.
- MEM/WB register update at each rising edge:
  - Non-memory op (Mem_i == 00): RegWrite_o <= WB_i, rd_addr_o <= rd_addr_i, wb_data_o <= ALUres_i.
  - Load completing (ack): RegWrite_o <= WB_i, rd_addr_o <= rd_addr_i, wb_data_o <= mem_rdata_i.
  - Store completing (ack): RegWrite_o <= WB_i, rd_addr_o <= rd_addr_i, wb_data_o <= ALUres_i.
  - Stalled cycle: bubble, RegWrite_o <= 0; rd_addr_o and wb_data_o hold.
  - Timeout abort: bubble, RegWrite_o <= 0.
  - Mem_i == 11: no memory request, bubble, err_o pulses the next cycle.
- mem_ack_i while mem_req_o = 0 is ignored.
- Latency: one cycle from stage input to the MEM/WB register when ack arrives the same cycle; N+1 cycles for N wait cycles.
- Misaligned addresses are passed through unchanged; alignment is the memory's responsibility.

Decomposition:
- Shared package constants:
  - MEM_NONE = 2'b00, MEM_READ = 2'b01, MEM_WRITE = 2'b10.
  - State encoding IDLE/WAIT.
- One sub-module, mem_wb_reg: the MEM/WB register with bubble insert and async active-low reset.
- The FSM, timeout counter and handshake stay in mem_wb_stage.

Test Plan:
- ALU op, Mem_i = 00, WB_i = 1, rd = 5, ALUres = 0x1234 -> next edge RegWrite_o = 1, rd_addr_o = 5, wb_data_o = 0x1234, stall_o never asserted.
- Load, Mem_i = 01, addr = 0x40, ack the same cycle with rdata = 0xDEADBEEF -> no stall; next edge wb_data_o = 0xDEADBEEF, RegWrite_o = 1.
- Store, Mem_i = 10, ack after 3 wait cycles -> mem_req_o/mem_we_o high 4 cycles, stall_o high 3 cycles, RegWrite_o = 0 bubbles, addr/wdata stable throughout.
- Load with no ack, TIMEOUT = 4 -> stall_o high 4 cycles, then release, err_o pulses once, RegWrite_o = 0, state IDLE.
- rst_i low during WAIT -> mem_req_o and outputs go to 0 immediately; an ack one cycle after reset release with no new op causes no MEM/WB update.
- Mem_i = 11 -> mem_req_o = 0, RegWrite_o = 0 next edge, err_o pulses once.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: memory-op codes, FSM states and op decode shared by the MEM stage
package mem_wb_stage_pkg;
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_READ = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] MEM_ILLEGAL = 2'b11;
  typedef enum logic {IDLE, WAIT} state_t;
  function automatic logic is_op(input logic [1:0] mem);
    return mem == MEM_READ || mem == MEM_WRITE;
  endfunction
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register that inserts a bubble whenever load is low
module mem_wb_reg import mem_wb_stage_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              next_reg_write,
  input  logic [4:0]        next_rd_addr,
  input  logic [DATA_W-1:0] next_wb_data,
  output logic              reg_write,
  output logic [4:0]        rd_addr,
  output logic [DATA_W-1:0] wb_data
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      rd_addr <= '0;
      wb_data <= '0;
    end else begin
      reg_write <= load && next_reg_write;
      if (load) begin
        rd_addr <= next_rd_addr;
        wb_data <= next_wb_data;
      end
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage with req/ack handshake, timeout abort and MEM/WB register
module mem_wb_stage import mem_wb_stage_pkg::*; #(
  parameter int TIMEOUT = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              WB_i,
  input  logic [1:0]        Mem_i,
  input  logic [DATA_W-1:0] Memaddr_i,
  input  logic [DATA_W-1:0] Memdata_i,
  input  logic [DATA_W-1:0] ALUres_i,
  input  logic [4:0]        rd_addr_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              RegWrite_o,
  output logic [4:0]        rd_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              err_o
);
  localparam int CW = $clog2(TIMEOUT + 2);
  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic op, done, timeout_hit, wait_more;
  assign op = is_op(Mem_i);
  assign done = op && mem_ack_i;
  assign timeout_hit = TIMEOUT != 0 && state == WAIT && op && !mem_ack_i && cnt == CW'(TIMEOUT);
  assign wait_more = op && !mem_ack_i && !timeout_hit;
  assign mem_req_o = rst_i && op;
  assign mem_we_o = Mem_i[1];
  assign mem_addr_o = Memaddr_i;
  assign mem_wdata_o = Memdata_i;
  assign stall_o = rst_i && wait_more;
  always_comb begin
    state_next = wait_more ? WAIT : IDLE;
    cnt_next = wait_more ? cnt + CW'(1) : '0;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt <= '0;
      err_o <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      err_o <= timeout_hit || Mem_i == MEM_ILLEGAL;
    end
  end
  mem_wb_reg #(.DATA_W(DATA_W)) u_reg (
    .clk(clk_i),
    .rst_n(rst_i),
    .load(Mem_i == MEM_NONE || done),
    .next_reg_write(WB_i),
    .next_rd_addr(rd_addr_i),
    .next_wb_data(Mem_i == MEM_READ ? mem_rdata_i : ALUres_i),
    .reg_write(RegWrite_o),
    .rd_addr(rd_addr_o),
    .wb_data(wb_data_o)
  );
endmodule
